// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects
// and RV32I register-field positions.
package pipe_ctrl_pkg;
  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] inst, input int lsb);
    return REG_W'(inst >> lsb);
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-content inputs and stall/flush/forward controls of the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic [31:0] inst_D, inst_E;
  logic        rd_en_E, reg_wr_E, br_taken_E, jump_E;
  logic [4:0]  rd_M, rd_W;
  logic        reg_wr_M, reg_wr_W;
  logic        dmem_req_M, dmem_ack;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E;
  logic [1:0]  fwd_a_E, fwd_b_E;
  logic        mem_err;

  modport slave (
    input  inst_D, inst_E, rd_en_E, reg_wr_E, br_taken_E, jump_E,
           rd_M, reg_wr_M, rd_W, reg_wr_W, dmem_req_M, dmem_ack,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           fwd_a_E, fwd_b_E, mem_err
  );

  modport master (
    output inst_D, inst_E, rd_en_E, reg_wr_E, br_taken_E, jump_E,
           rd_M, reg_wr_M, rd_W, reg_wr_W, dmem_req_M, dmem_ack,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
           fwd_a_E, fwd_b_E, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forward select for one execute-stage source register; M beats W, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic             wr_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             wr_w_i,
  output fwd_sel_e         sel_o
);
  always_comb begin
    sel_o = FWD_RF;
    if (wr_m_i && (rd_m_i != '0) && (rd_m_i == rs_i))      sel_o = FWD_M;
    else if (wr_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) sel_o = FWD_W;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use, branch flush,
// forwarding and memory-wait FSM with timeout. Optional perf counters under PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  pipeline_hazard_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_timeout
`endif
);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q;
  logic       to_hit;
  logic       stall_all, stall_fd, flush_d, flush_e;
  logic       load_use;

  logic [REG_W-1:0] rs1_d, rs2_d, rd_e;
  logic [1:0][REG_W-1:0] rs_e;
  fwd_sel_e [1:0] fwd_sel;

  assign rs1_d   = reg_field(bus.inst_D, RS1_LSB);
  assign rs2_d   = reg_field(bus.inst_D, RS2_LSB);
  assign rd_e    = reg_field(bus.inst_E, RD_LSB);
  assign rs_e[0] = reg_field(bus.inst_E, RS1_LSB);
  assign rs_e[1] = reg_field(bus.inst_E, RS2_LSB);

  assign load_use = bus.rd_en_E && bus.reg_wr_E && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    to_hit     = 1'b0;
    stall_all  = 1'b0;
    stall_fd   = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        // Wrong-path decode makes load-use moot, so redirect outranks it.
        if (bus.dmem_req_M && !bus.dmem_ack) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
        end else if (bus.br_taken_E || bus.jump_E) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall_all = 1'b1;
        if (bus.dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          to_hit     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_q | to_hit;
    end
  end

  assign bus.stall_F = stall_all | stall_fd;
  assign bus.stall_D = stall_all | stall_fd;
  assign bus.stall_E = stall_all;
  assign bus.stall_M = stall_all;
  assign bus.flush_D = flush_d;
  assign bus.flush_E = flush_e;
  assign bus.mem_err = mem_err_q;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_unit u_fwd (
      .rs_i   (rs_e[g]),
      .rd_m_i (bus.rd_M),
      .wr_m_i (bus.reg_wr_M),
      .rd_w_i (bus.rd_W),
      .wr_w_i (bus.reg_wr_W),
      .sel_o  (fwd_sel[g])
    );
  end

  assign bus.fwd_a_E = fwd_sel[0];
  assign bus.fwd_b_E = fwd_sel[1];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q, timeout_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q   <= '0;
      flush_events_q   <= '0;
      timeout_events_q <= '0;
    end else begin
      if ((state_q == MEM_WAIT) || stall_fd) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_d || flush_e)                flush_events_q <= flush_events_q + 32'd1;
      if (to_hit)                            timeout_events_q <= timeout_events_q + 32'd1;
    end
  end

  assign perf_stall   = stall_cycles_q;
  assign perf_flush   = flush_events_q;
  assign perf_timeout = timeout_events_q;
`endif
endmodule
